// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter.
// Imported by the arbiter top and the round-robin picker.
package fifo_arb_pkg;

    localparam int cDefBits   = 8;
    localparam int cDefN      = 4;
    localparam int cDefMaxLen = 16;

    typedef enum logic {
        sIdle = 1'b0,
        sXfer = 1'b1
    } arbState_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request after lastOwner, with wrap.
// Output is one-hot, all-zero when nothing requests.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int pN = cDefN
) (
    input  logic [pN-1:0]         req,
    input  logic [$clog2(pN)-1:0] lastOwner,
    output logic [pN-1:0]         winner
);

    localparam int cIW = $clog2(pN);

    logic           found;
    logic [cIW:0]   sum;
    logic [cIW-1:0] idx;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int i = 1; i <= pN; i++) begin
            sum = {1'b0, lastOwner} + (cIW+1)'(i);
            if (sum >= (cIW+1)'(pN)) begin
                sum = sum - (cIW+1)'(pN);
            end
            idx = sum[cIW-1:0];
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter feeding one downstream FIFO write port.
// A grant holds until the owner's last beat or the beat limit is reached.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int pBITS    = cDefBits,
    parameter int pN       = cDefN,
    parameter int pMAX_LEN = cDefMaxLen
) (
    input  logic                iclk,
    input  logic                ireset,
    input  logic [pN-1:0]       ireq,
    input  logic [pN-1:0]       ivalid,
    input  logic [pN-1:0]       ilast,
    input  logic [pN*pBITS-1:0] iw_data,
    output logic [pN-1:0]       oready,
    input  logic                ifull,
    output logic                owr,
    output logic [pBITS-1:0]    ow_data,
    output logic [pN-1:0]       ogrant,
    output logic                oerr
);

    localparam int cIW = $clog2(pN);
    localparam int cCW = $clog2(pMAX_LEN + 1);
    localparam logic [cCW-1:0] cLastCnt = cCW'(pMAX_LEN - 1);

    arbState_t      state;
    arbState_t      stateNext;
    logic [pN-1:0]  grant;
    logic [pN-1:0]  grantNext;
    logic [pN-1:0]  pick;
    logic [cIW-1:0] lastOwner;
    logic [cIW-1:0] lastOwnerNext;
    logic [cIW-1:0] ownerIdx;
    logic [cCW-1:0] count;
    logic [cCW-1:0] countNext;
    logic           err;
    logic           errNext;
    logic           accept;

    rr_picker #(.pN(pN)) uPicker (
        .req       (ireq),
        .lastOwner (lastOwner),
        .winner    (pick)
    );

    always_comb begin
        ownerIdx = '0;
        for (int i = 0; i < pN; i++) begin
            if (grant[i]) begin
                ownerIdx = cIW'(i);
            end
        end
    end

    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            state     <= sIdle;
            grant     <= '0;
            lastOwner <= cIW'(pN - 1);
            count     <= '0;
            err       <= 1'b0;
        end else begin
            state     <= stateNext;
            grant     <= grantNext;
            lastOwner <= lastOwnerNext;
            count     <= countNext;
            err       <= errNext;
        end
    end

    always_comb begin
        stateNext     = state;
        grantNext     = grant;
        lastOwnerNext = lastOwner;
        countNext     = count;
        errNext       = 1'b0;
        accept        = 1'b0;
        unique case (state)
            sIdle: begin
                if (|ireq) begin
                    grantNext = pick;
                    countNext = '0;
                    stateNext = sXfer;
                end
            end
            sXfer: begin
                accept = ivalid[ownerIdx] && !ifull;
                if (accept) begin
                    countNext = count + 1'b1;
                    // Limit release is flagged only when no ilast came with it
                    if (ilast[ownerIdx] || count == cLastCnt) begin
                        stateNext     = sIdle;
                        grantNext     = '0;
                        lastOwnerNext = ownerIdx;
                        errNext       = !ilast[ownerIdx];
                    end
                end
            end
            default: begin
                stateNext = sIdle;
                grantNext = '0;
            end
        endcase
    end

    assign owr     = accept;
    assign oready  = accept ? grant : '0;
    assign ow_data = (state == sXfer) ?
                     iw_data[ownerIdx*pBITS +: pBITS] : '0;
    assign ogrant  = grant;
    assign oerr    = err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with immediate-assertion checks.
// Inputs change 1ns after a rising edge, outputs are checked 1ns later.
module tb_fifo_wr_arbiter;

    localparam int cB = 8;
    localparam int cN = 4;

    logic            iclk;
    logic            ireset;
    logic [cN-1:0]   ireq;
    logic [cN-1:0]   ivalid;
    logic [cN-1:0]   ilast;
    logic [cN*cB-1:0] iw_data;
    logic [cN-1:0]   oready;
    logic            ifull;
    logic            owr;
    logic [cB-1:0]   ow_data;
    logic [cN-1:0]   ogrant;
    logic            oerr;

    int total = 0;
    int bad   = 0;

    fifo_wr_arbiter #(.pBITS(cB), .pN(cN), .pMAX_LEN(16)) dut (
        .iclk    (iclk),
        .ireset  (ireset),
        .ireq    (ireq),
        .ivalid  (ivalid),
        .ilast   (ilast),
        .iw_data (iw_data),
        .oready  (oready),
        .ifull   (ifull),
        .owr     (owr),
        .ow_data (ow_data),
        .ogrant  (ogrant),
        .oerr    (oerr)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic setData(input int k, input logic [cB-1:0] v);
        iw_data[k*cB +: cB] = v;
    endtask

    task automatic chkBeat(input string tag, input logic [cN-1:0] g,
                           input logic [cB-1:0] d);
        chk({tag, "_owr"}, 32'(owr), 32'd1);
        chk({tag, "_grant"}, 32'(ogrant), 32'(g));
        chk({tag, "_ready"}, 32'(oready), 32'(g));
        chk({tag, "_data"}, 32'(ow_data), 32'(d));
    endtask

    task automatic chkQuiet(input string tag, input logic [cN-1:0] g);
        chk({tag, "_owr"}, 32'(owr), 32'd0);
        chk({tag, "_ready"}, 32'(oready), 32'd0);
        chk({tag, "_grant"}, 32'(ogrant), 32'(g));
    endtask

    task automatic doReset();
        ireset = 1'b1;
        cyc();
        ireset = 1'b0;
        settle();
    endtask

    initial begin
        ireset  = 1'b1;
        ireq    = '0;
        ivalid  = '0;
        ilast   = '0;
        iw_data = '0;
        ifull   = 1'b0;
        cyc();
        cyc();
        chkQuiet("rst", 4'b0000);
        chk("rst_err", 32'(oerr), 32'd0);
        ireset = 1'b0;
        settle();

        // single requester, 3-beat packet
        ireq   = 4'b0010;
        ivalid = 4'b0010;
        setData(1, 8'hA1);
        settle();
        chkQuiet("p1_idle", 4'b0000);
        cyc();
        chkBeat("p1_b1", 4'b0010, 8'hA1);
        cyc();
        setData(1, 8'hA2);
        settle();
        chkBeat("p1_b2", 4'b0010, 8'hA2);
        cyc();
        setData(1, 8'hA3);
        ilast = 4'b0010;
        settle();
        chkBeat("p1_b3", 4'b0010, 8'hA3);
        ireq = '0;
        cyc();
        chkQuiet("p1_end", 4'b0000);
        ivalid = '0;
        ilast  = '0;

        // all requesters, 1-beat packets, round-robin order
        doReset();
        ireq   = 4'b1111;
        ivalid = 4'b1111;
        ilast  = 4'b1111;
        for (int k = 0; k < cN; k++) setData(k, 8'(8'h10 + k));
        settle();
        for (int s = 0; s < 5; s++) begin
            chkQuiet($sformatf("rr%0d_bubble", s), 4'b0000);
            cyc();
            chkBeat($sformatf("rr%0d", s), 4'(1 << (s % cN)),
                    8'(8'h10 + (s % cN)));
            cyc();
        end
        ireq   = '0;
        ivalid = '0;
        ilast  = '0;
        cyc();
        chkQuiet("rr_end", 4'b0000);

        // full stall mid-packet on requester 2 (lastOwner is 0)
        ireq = 4'b0100;
        ivalid = 4'b0100;
        setData(2, 8'hB1);
        cyc();
        chkBeat("st_b1", 4'b0100, 8'hB1);
        cyc();
        setData(2, 8'hB2);
        ifull = 1'b1;
        settle();
        chkQuiet("st_full1", 4'b0100);
        chk("st_full1_data", 32'(ow_data), 32'hB2);
        cyc();
        chkQuiet("st_full2", 4'b0100);
        chk("st_full2_data", 32'(ow_data), 32'hB2);
        cyc();
        ifull = 1'b0;
        settle();
        chkBeat("st_b2", 4'b0100, 8'hB2);
        cyc();
        setData(2, 8'hB3);
        ilast = 4'b0100;
        settle();
        chkBeat("st_b3", 4'b0100, 8'hB3);
        ireq = '0;
        cyc();
        chkQuiet("st_end", 4'b0000);
        ivalid = '0;
        ilast  = '0;

        // beat limit: requester 3 sends 16 beats without ilast
        ireq   = 4'b1001;
        ivalid = 4'b1000;
        cyc();
        for (int b = 0; b < 16; b++) begin
            setData(3, 8'(8'hC0 + b));
            settle();
            chkBeat($sformatf("ml_b%0d", b), 4'b1000, 8'(8'hC0 + b));
            chk($sformatf("ml_err%0d", b), 32'(oerr), 32'd0);
            cyc();
        end
        chkQuiet("ml_rel", 4'b0000);
        chk("ml_err_pulse", 32'(oerr), 32'd1);
        ivalid = 4'b0001;
        ilast  = 4'b0001;
        setData(0, 8'hD0);
        cyc();
        chk("ml_err_clr", 32'(oerr), 32'd0);
        chkBeat("ml_next", 4'b0001, 8'hD0);
        ireq = '0;
        cyc();
        chkQuiet("ml_next_end", 4'b0000);

        // reset during beat 2: lastOwner 0 would pick 1, reset makes 0 win
        ireq   = 4'b0011;
        ivalid = 4'b0010;
        ilast  = '0;
        setData(1, 8'hE1);
        cyc();
        chkBeat("rs_b1", 4'b0010, 8'hE1);
        cyc();
        setData(1, 8'hE2);
        settle();
        chkBeat("rs_b2", 4'b0010, 8'hE2);
        ireset = 1'b1;
        settle();
        chkQuiet("rs_abort", 4'b0000);
        cyc();
        chkQuiet("rs_hold", 4'b0000);
        ireset = 1'b0;
        ivalid = 4'b0001;
        ilast  = 4'b0001;
        setData(0, 8'hE0);
        cyc();
        chkBeat("rs_win0", 4'b0001, 8'hE0);
        ireq = '0;
        cyc();
        chkQuiet("rs_end", 4'b0000);

        // non-owner noise during requester 1's packet
        ireq   = 4'b0010;
        ivalid = 4'b0000;
        ilast  = 4'b0000;
        cyc();
        chkQuiet("no_wait", 4'b0010);
        ireq   = 4'b1111;
        ivalid = 4'b1111;
        ilast  = 4'b1101;
        for (int k = 0; k < cN; k++) setData(k, 8'(8'h50 + k));
        setData(1, 8'hF1);
        settle();
        chkBeat("no_b1", 4'b0010, 8'hF1);
        cyc();
        ivalid = 4'b0110;
        ilast  = 4'b0101;
        setData(1, 8'hF2);
        settle();
        chkBeat("no_b2", 4'b0010, 8'hF2);
        cyc();
        ivalid = 4'b1000;
        ilast  = 4'b1001;
        settle();
        chkQuiet("no_gap", 4'b0010);
        cyc();
        ireq   = 4'b0000;
        ivalid = 4'b1011;
        ilast  = 4'b0010;
        setData(1, 8'hF3);
        settle();
        chkBeat("no_b3", 4'b0010, 8'hF3);
        cyc();
        chkQuiet("no_end", 4'b0000);
        chk("no_err", 32'(oerr), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
